clock_rate_meter: RTL

//  Measures the rate of the board clock that feeds the CPU core. That clock is

---
 rtl/clock_rate_meter.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/clock_rate_meter.sv
// rtl/clock_rate_meter.sv - gated rising-edge counter measuring a slow asynchronous clock
// Optional min/max result tracking is enabled by defining CLOCK_RATE_METER_MINMAX_EN.
module clock_rate_meter #(
    parameter int unsigned GATE_CYCLES = 50_000_000,
    parameter int unsigned COUNT_W     = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               clock_meas,
    input  logic               clear,
    output logic               edge_pulse,
    output logic [COUNT_W-1:0] freq_count,
    output logic               valid,
    output logic               overflow,
    output logic               stalled
`ifdef CLOCK_RATE_METER_MINMAX_EN
    ,
    output logic [COUNT_W-1:0] min_count,
    output logic [COUNT_W-1:0] max_count
`endif
);

    localparam int GATE_W = (GATE_CYCLES > 2) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [GATE_W-1:0]  GATE_LAST = GATE_W'(GATE_CYCLES - 1);
    localparam logic [COUNT_W-1:0] CNT_MAX   = '1;

    typedef enum logic {
        ST_ARM     = 1'b0,
        ST_MEASURE = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic                s1_q, s2_q, s3_q;
    logic [GATE_W-1:0]   gate_q, gate_d;
    logic [GATE_W-1:0]   tmo_q, tmo_d;
    logic [COUNT_W-1:0]  cnt_q, cnt_d;
    logic                ovf_acc_q, ovf_acc_d;
    logic [COUNT_W-1:0]  freq_q;
    logic                ovf_q, stalled_q, valid_q;

    logic                publish;
    logic [COUNT_W-1:0]  pub_count;
    logic                pub_ovf;
    logic                cnt_sat;
    logic [COUNT_W-1:0]  cnt_upd;
    logic                ovf_upd;

    assign edge_pulse = s2_q & ~s3_q;
    assign cnt_sat    = (cnt_q == CNT_MAX);

    always_comb begin
        state_d   = state_q;
        gate_d    = gate_q;
        tmo_d     = tmo_q;
        cnt_d     = cnt_q;
        ovf_acc_d = ovf_acc_q;
        publish   = 1'b0;
        pub_count = '0;
        pub_ovf   = 1'b0;
        // Count including this cycle's edge; saturates and flags overflow instead of wrapping.
        cnt_upd   = (edge_pulse && !cnt_sat) ? cnt_q + COUNT_W'(1) : cnt_q;
        ovf_upd   = ovf_acc_q | (edge_pulse & cnt_sat);

        if (clear) begin
            state_d   = ST_ARM;
            gate_d    = '0;
            tmo_d     = '0;
            cnt_d     = '0;
            ovf_acc_d = 1'b0;
        end else begin
            case (state_q)
                ST_ARM: begin
                    if (edge_pulse) begin
                        state_d   = ST_MEASURE;
                        gate_d    = GATE_W'(1);
                        cnt_d     = COUNT_W'(1);
                        ovf_acc_d = 1'b0;
                        tmo_d     = '0;
                    end else if (tmo_q == GATE_LAST) begin
                        publish = 1'b1;
                        tmo_d   = '0;
                    end else begin
                        tmo_d = tmo_q + GATE_W'(1);
                    end
                end
                ST_MEASURE: begin
                    if (gate_q == GATE_LAST) begin
                        publish   = 1'b1;
                        pub_count = cnt_upd;
                        pub_ovf   = ovf_upd;
                        // Next window begins on the following cycle with no dead time.
                        gate_d    = '0;
                        cnt_d     = '0;
                        ovf_acc_d = 1'b0;
                        if (cnt_upd == '0) begin
                            state_d = ST_ARM;
                            tmo_d   = '0;
                        end
                    end else begin
                        gate_d    = gate_q + GATE_W'(1);
                        cnt_d     = cnt_upd;
                        ovf_acc_d = ovf_upd;
                    end
                end
                default: begin
                    state_d = ST_ARM;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
            s3_q      <= 1'b0;
            state_q   <= ST_ARM;
            gate_q    <= '0;
            tmo_q     <= '0;
            cnt_q     <= '0;
            ovf_acc_q <= 1'b0;
            freq_q    <= '0;
            ovf_q     <= 1'b0;
            stalled_q <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            s1_q      <= clock_meas;
            s2_q      <= s1_q;
            s3_q      <= s2_q;
            state_q   <= state_d;
            gate_q    <= gate_d;
            tmo_q     <= tmo_d;
            cnt_q     <= cnt_d;
            ovf_acc_q <= ovf_acc_d;
            valid_q   <= publish;
            if (publish) begin
                freq_q    <= pub_count;
                ovf_q     <= pub_ovf;
                stalled_q <= (pub_count == '0);
            end
        end
    end

    assign freq_count = freq_q;
    assign overflow   = ovf_q;
    assign stalled    = stalled_q;
    assign valid      = valid_q;

`ifdef CLOCK_RATE_METER_MINMAX_EN
    logic [COUNT_W-1:0] min_q, max_q;

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            min_q <= '1;
            max_q <= '0;
        end else if (publish) begin
            if (pub_count < min_q) min_q <= pub_count;
            if (pub_count > max_q) max_q <= pub_count;
        end
    end

    assign min_count = min_q;
    assign max_count = max_q;
`endif

endmodule
